// File: rtl/prio_pkg.sv
// prio_pkg: shared constants, FSM state type and width helper for the priority arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prio_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit so that
  // counters sized from it stay legal when the feature they serve is disabled.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational winner search over a request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are stable.
//
// Ports:
//   req     N     request vector
//   start   IDXW  rotation pointer (index of the most recent owner)
//   rr_mode 1     0 = highest index wins, 1 = search start-1 downward, wrapping, start last
//   idx     IDXW  winning index (0 when nothing found)
//   found   1     at least one request was set
module prio_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  input  logic            rr_mode,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  int              base;
  int              cand;
  logic [IDXW-1:0] cand_idx;

  // Candidate k is (base - k) mod N for k = 1..N. With base = 0 this visits
  // N-1 down to 0, i.e. plain fixed priority; with base = last owner it visits
  // last-1, last-2, ... wrapping, and the last owner itself comes up last.
  always_comb begin
    idx      = '0;
    found    = 1'b0;
    base     = rr_mode ? int'(start) : 0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (base + N - k) % N;
      cand_idx = IDXW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: N-way registered arbiter, fixed priority or round-robin, with optional hold timeout.
// Latency: 1 cycle from req to gnt; a grant that ends re-arbitrates on the same edge (no idle bubble).
// Backpressure: none; the owner keeps gnt until it drops req, pulses rel, or reaches MAX_HOLD cycles.
//
// Ports:
//   clk        1     system clock, rising edge
//   rst_n      1     asynchronous active-low reset
//   req        N     level-sensitive request vector
//   rel        1     one-cycle release pulse from the current owner
//                    (named rel because "release" is a reserved word)
//   gnt        N     one-hot registered grant, zero when idle
//   gnt_idx    IDXW  binary owner index, zero when idle
//   gnt_valid  1     a grant is active
//   timeout    1     one-cycle pulse: grant ended solely because of MAX_HOLD
module prio_arbiter
  import prio_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MODE     = 0,
  parameter  int MAX_HOLD = 0,
  localparam int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            rel,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int              HW        = clog2_min1(MAX_HOLD + 1);
  localparam logic            TO_EN     = (MAX_HOLD != 0);
  localparam logic            RR_EN     = (MODE == MODE_RR);
  localparam logic [HW-1:0]   HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [IDXW-1:0] last_ptr;

  logic            own_drop;
  logic            to_hit;
  logic            grant_end;
  logic            arb_now;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [N-1:0]    pick_onehot;

  // The pointer is the most recent owner; in fixed mode the picker ignores it.
  prio_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req     (req),
    .start   (last_ptr),
    .rr_mode (RR_EN),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // All end causes fold into one event so simultaneous causes re-arbitrate once.
  always_comb begin
    own_drop  = (state == GRANT) && !req[gnt_idx];
    to_hit    = (state == GRANT) && TO_EN && (hold_cnt == HOLD_LAST);
    grant_end = (state == GRANT) && (own_drop || rel || to_hit);
    arb_now   = (state == IDLE) || grant_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      last_ptr  <= '0;
    end else begin
      // Flag a timeout only when the hold limit was the sole reason to end.
      timeout <= to_hit && !own_drop && !rel;

      if (arb_now) begin
        hold_cnt <= '0;
        if (pick_found) begin
          state     <= GRANT;
          gnt       <= pick_onehot;
          gnt_idx   <= pick_idx;
          gnt_valid <= 1'b1;
          last_ptr  <= pick_idx;
        end else begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
        end
      end else if (TO_EN) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
module tb_prio_arbiter;

  localparam logic [1:0] FX = 2'd0;  // N=4 fixed priority, MAX_HOLD=4
  localparam logic [1:0] RR = 2'd1;  // N=4 round-robin,   MAX_HOLD=4
  localparam logic [1:0] N3 = 2'd2;  // N=3 fixed priority, no timeout

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic       rel   = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] gnt_fx, gnt_rr;
  logic [2:0] gnt_n3;
  logic [1:0] idx_fx, idx_rr, idx_n3;
  logic       vld_fx, vld_rr, vld_n3;
  logic       to_fx, to_rr, to_n3;

  prio_arbiter #(.N(4), .MODE(0), .MAX_HOLD(4)) u_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(gnt_fx), .gnt_idx(idx_fx), .gnt_valid(vld_fx), .timeout(to_fx)
  );

  prio_arbiter #(.N(4), .MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(gnt_rr), .gnt_idx(idx_rr), .gnt_valid(vld_rr), .timeout(to_rr)
  );

  prio_arbiter #(.N(3), .MODE(0), .MAX_HOLD(0)) u_n3 (
    .clk(clk), .rst_n(rst_n), .req(req[2:0]), .rel(rel),
    .gnt(gnt_n3), .gnt_idx(idx_n3), .gnt_valid(vld_n3), .timeout(to_n3)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic logic [7:0] observe(input logic [1:0] sel);
    case (sel)
      FX:      return {gnt_fx, idx_fx, vld_fx, to_fx};
      RR:      return {gnt_rr, idx_rr, vld_rr, to_rr};
      default: return {1'b0, gnt_n3, idx_n3, vld_n3, to_n3};
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, required gnt=%b idx=%0d vld=%b to=%b",
                  tag, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  task automatic push(input logic [1:0] sel, input logic [3:0] g, input logic [1:0] i,
                      input logic v, input logic t, input string tag);
    exp_t e;
    e.sel = sel; e.gnt = g; e.idx = i; e.vld = v; e.to = t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive inputs at the falling edge; the expectation is for the next rising edge.
  task automatic step(input logic [1:0] sel, input logic [3:0] r, input logic rl,
                      input logic [3:0] g, input logic [1:0] i, input logic v, input logic t,
                      input string tag);
    @(negedge clk);
    req = r;
    rel = rl;
    push(sel, g, i, v, t, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0000; rel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per rising edge, compared 1 time unit after it.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, observe(e.sel), {e.gnt, e.idx, e.vld, e.to});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1);
  end

  int         rr_seq[9] = '{3, 3, 2, 2, 1, 1, 0, 0, 3};
  logic [1:0] ri;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-grant clears outputs without a clock edge.
    step(FX, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "fx_first_grant");
    step(FX, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "fx_first_hold");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async", observe(FX), 8'h00);
    step(FX, 4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_held");
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0000;
    step(FX, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_release_ignored");
    @(negedge clk);
    rel = 1'b0; req = 4'b1000;
    #2;
    req = 4'b0000;
    push(FX, 4'b0000, 2'd0, 1'b0, 1'b0, "req_glitch_ignored");

    // Fixed priority pick and bubble-free handoff.
    step(FX, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "fx_pick_highest");
    step(FX, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "fx_handoff_no_bubble");
    step(FX, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "fx_new_owner_hold");
    step(FX, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "fx_to_idle");

    // Release and re-win; the release restarts the hold count.
    do_reset();
    step(FX, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rewin_grant");
    step(FX, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rewin_hold");
    step(FX, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, "rewin_release");
    repeat (3) step(FX, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rewin_cnt_restart");
    step(FX, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, "rewin_timeout");
    step(FX, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rewin_timeout_pulse");
    step(FX, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rewin_idle");

    // Fixed-mode timeout: same owner wins again.
    do_reset();
    repeat (4) step(FX, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "fx_to_hold");
    step(FX, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "fx_timeout_regrant");
    step(FX, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "fx_to_idle2");

    // Round-robin fairness with release every second cycle.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      ri = rr_seq[k][1:0];
      step(RR, 4'b1111, (k > 0) && (k % 2 == 0), 4'b0001 << ri, ri, 1'b1, 1'b0, "rr_fair");
    end
    step(RR, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

    // Round-robin timeout hands the grant to the other requester.
    do_reset();
    repeat (4) step(RR, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_to_hold");
    step(RR, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "rr_timeout_rotate");
    step(RR, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_after_timeout");
    step(RR, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_drop_handoff");
    step(RR, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle2");

    // Simultaneous end causes collapse into one re-arbitration without timeout.
    do_reset();
    repeat (4) step(FX, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "sim_hold");
    step(FX, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "sim_triple_end");
    repeat (3) step(FX, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "sim_new_hold");
    step(FX, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "sim_release_and_timeout");
    step(FX, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "sim_after");
    step(FX, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "sim_idle");

    // Three-input legacy encoding: gnt_idx+1 is the old {d,e} code.
    do_reset();
    step(N3, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "n3_c");
    step(N3, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "n3_nonowner_ignored");
    step(N3, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "n3_b");
    step(N3, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "n3_a_waits");
    step(N3, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "n3_a");
    step(N3, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "n3_idle");

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
